// File: rtl/mem_stage_pkg.sv
// Shared opcode/funct3 encodings, FSM states and the misalignment/illegal-op
// predicate used by the memory stage.
package mem_stage_pkg;

    localparam logic [4:0] OP_LOAD  = 5'b00000;
    localparam logic [4:0] OP_STORE = 5'b01000;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // funct3[1:0] is the access size for both signed and unsigned variants.
    function automatic logic mem_op_illegal(input logic       is_load,
                                            input logic [2:0] funct3,
                                            input logic [1:0] off);
        logic bad;
        bad = 1'b0;
        if (is_load) begin
            bad = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        end else begin
            bad = (funct3 > F3_W);
        end
        if ((funct3[1:0] == 2'b01) && off[0]) begin
            bad = 1'b1;
        end
        if ((funct3[1:0] == 2'b10) && (off != 2'b00)) begin
            bad = 1'b1;
        end
        return bad;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_align.sv
// Byte-lane alignment: store byte enables / lane replication and load
// lane extraction with sign or zero extension. Purely combinational.
module mem_stage_lsu_align
    import mem_stage_pkg::*;
(
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  off_i,
    input  logic [31:0] store_data_i,
    input  logic [31:0] load_word_i,
    output logic [3:0]  be_o,
    output logic [31:0] wdata_o,
    output logic [31:0] load_data_o
);

    logic [4:0]  lane_sh;
    logic [31:0] shifted;

    always_comb begin
        lane_sh = {off_i, 3'b000};
        shifted = load_word_i >> lane_sh;

        be_o    = 4'b1111;
        wdata_o = store_data_i;
        case (funct3_i[1:0])
            2'b00: begin
                be_o    = 4'b0001 << off_i;
                wdata_o = {4{store_data_i[7:0]}};
            end
            2'b01: begin
                be_o    = 4'b0011 << off_i;
                wdata_o = {2{store_data_i[15:0]}};
            end
            default: begin
                be_o    = 4'b1111;
                wdata_o = store_data_i;
            end
        endcase

        load_data_o = load_word_i;
        case (funct3_i)
            F3_B:    load_data_o = {{24{shifted[7]}}, shifted[7:0]};
            F3_BU:   load_data_o = {24'h000000, shifted[7:0]};
            F3_H:    load_data_o = {{16{shifted[15]}}, shifted[15:0]};
            F3_HU:   load_data_o = {16'h0000, shifted[15:0]};
            default: load_data_o = load_word_i;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: runs LOAD/STORE over a req/ack data port and
// registers the result into the MEM/WB register; other ops pass in one cycle.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int RFW = 5,
    parameter int IMW = 4,
    parameter int DW  = 32,
    parameter int IW  = 32
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [IW-1:0]  inst,
    input  logic [RFW-1:0] rd,
    input  logic [DW-1:0]  alu_res,
    input  logic [DW-1:0]  rs2_data,
    output logic           dmem_req,
    output logic           dmem_we,
    output logic [DW-1:0]  dmem_addr,
    output logic [DW-1:0]  dmem_wdata,
    output logic [IMW-1:0] dmem_be,
    input  logic           dmem_ack,
    input  logic [DW-1:0]  dmem_rdata,
    output logic           wb_valid,
    output logic [IW-1:0]  wb_inst,
    output logic [RFW-1:0] wb_rd,
    output logic [DW-1:0]  wb_data,
    output logic           wb_err
);

    state_e state_q, state_d;

    logic           req_q, we_q;
    logic [DW-1:0]  addr_q, wdata_q;
    logic [IMW-1:0] be_q;
    logic [IW-1:0]  inst_q;
    logic [RFW-1:0] rd_q;
    logic [2:0]     f3_q;
    logic [1:0]     off_q;

    logic           wb_valid_q, wb_err_q;
    logic [IW-1:0]  wb_inst_q;
    logic [RFW-1:0] wb_rd_q;
    logic [DW-1:0]  wb_data_q;

    logic [4:0] opcode;
    logic [2:0] funct3;
    logic [1:0] off;
    logic       is_load, is_store, is_mem, illegal, accept;

    logic [2:0]     align_f3;
    logic [1:0]     align_off;
    logic [IMW-1:0] align_be;
    logic [DW-1:0]  align_wdata, align_load;

    assign opcode   = inst[6:2];
    assign funct3   = inst[14:12];
    assign off      = alu_res[1:0];
    assign is_load  = (opcode == OP_LOAD);
    assign is_store = (opcode == OP_STORE);
    assign is_mem   = is_load | is_store;
    assign illegal  = mem_op_illegal(is_load, funct3, off);
    assign accept   = in_valid & in_ready;

    // The aligner serves the store path at accept time and the load path at ack time.
    assign align_f3  = (state_q == ST_REQ) ? f3_q  : funct3;
    assign align_off = (state_q == ST_REQ) ? off_q : off;

    mem_stage_lsu_align u_lsu_align (
        .funct3_i     (align_f3),
        .off_i        (align_off),
        .store_data_i (rs2_data),
        .load_word_i  (dmem_rdata),
        .be_o         (align_be),
        .wdata_o      (align_wdata),
        .load_data_o  (align_load)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept && is_mem && !illegal) state_d = ST_REQ;
            ST_REQ:  if (dmem_ack) state_d = ST_DONE;
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state_q == ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            be_q       <= '0;
            inst_q     <= '0;
            rd_q       <= '0;
            f3_q       <= '0;
            off_q      <= '0;
            wb_valid_q <= 1'b0;
            wb_inst_q  <= '0;
            wb_rd_q    <= '0;
            wb_data_q  <= '0;
            wb_err_q   <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_mem || illegal) begin
                            wb_valid_q <= 1'b1;
                            wb_inst_q  <= inst;
                            wb_rd_q    <= rd;
                            wb_data_q  <= is_mem ? '0 : alu_res;
                            wb_err_q   <= is_mem;
                        end else begin
                            inst_q  <= inst;
                            rd_q    <= rd;
                            f3_q    <= funct3;
                            off_q   <= off;
                            req_q   <= 1'b1;
                            we_q    <= is_store;
                            addr_q  <= {alu_res[DW-1:2], 2'b00};
                            be_q    <= align_be;
                            wdata_q <= align_wdata;
                        end
                    end
                end
                ST_REQ: begin
                    // Result is registered on the ack edge so it is visible during DONE.
                    if (dmem_ack) begin
                        req_q      <= 1'b0;
                        wb_valid_q <= 1'b1;
                        wb_inst_q  <= inst_q;
                        wb_rd_q    <= rd_q;
                        wb_data_q  <= we_q ? '0 : align_load;
                        wb_err_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign dmem_req   = req_q;
    assign dmem_we    = we_q;
    assign dmem_addr  = addr_q;
    assign dmem_wdata = wdata_q;
    assign dmem_be    = be_q;
    assign wb_valid   = wb_valid_q;
    assign wb_inst    = wb_inst_q;
    assign wb_rd      = wb_rd_q;
    assign wb_data    = wb_data_q;
    assign wb_err     = wb_err_q;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access pipeline stage; sits between execute and write-back.
- Accepts one instruction per handshake and runs LOAD/STORE against a request/acknowledge data-memory port, with byte-lane alignment and load sign/zero extension.
- Registers inst/rd/result into the MEM/WB pipeline register that feeds write-back.
- Non-memory instructions pass through with one-cycle latency.

Parameters:
RFW, 5, register-file index width (rd)
IMW, 4, byte-enable width (DW/8)
DW, 32, data/address width; memory ops defined for DW=32 only
IW, 32, instruction width

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  synchronous, active-high reset
in_valid  in  1  upstream instruction valid
in_ready  out  1  stage can accept; transfer when in_valid&in_ready
inst  in  IW  instruction from execute
rd  in  RFW  destination register index
alu_res  in  DW  ALU result / effective address
rs2_data  in  DW  store data
dmem_req  out  1  memory request, held until dmem_ack
dmem_we  out  1  1=store, 0=load
dmem_addr  out  DW  word-aligned address (alu_res with [1:0]=0)
dmem_wdata  out  DW  store data replicated into lanes
dmem_be  out  IMW  byte enables
dmem_ack  in  1  one-cycle acknowledge; dmem_rdata valid same cycle
dmem_rdata  in  DW  load word
wb_valid  out  1  MEM/WB register valid
wb_inst  out  IW  instruction to write-back
wb_rd  out  RFW  destination index to write-back
wb_data  out  DW  result to write-back
wb_err  out  1  misaligned or illegal-funct3 memory op

Behaviour:
- Decode: opcode=inst[6:2]; LOAD=5'b00000, STORE=5'b01000; funct3=inst[14:12]; off=alu_res[1:0].
- Reset: state IDLE; in_ready=1 on the following cycle; dmem_req=0, dmem_we=0, dmem_be=0, dmem_addr=0, dmem_wdata=0; wb_valid=0, wb_inst=0, wb_rd=0, wb_data=0, wb_err=0.
- FSM states: IDLE, REQ, DONE. in_ready=1 only in IDLE.
- IDLE, accept of non-memory op: next cycle wb_valid=1, wb_data=alu_res, wb_err=0, wb_inst/wb_rd copied; stay IDLE.
- IDLE, no accept: wb_valid=0 next cycle. Other wb_* hold.
- IDLE, accept of LOAD/STORE:
  - Illegal: load funct3 in {011,110,111}; store funct3 >010; H with off[0]=1; W with off!=0.
  - Illegal access: no request; next cycle wb_valid=1, wb_err=1, wb_data=0; stay IDLE.
  - Legal access: capture inst/rd/funct3/off; next cycle dmem_req=1 with registered addr/we/be/wdata; go REQ.
- Byte enables: B -> 4'b0001<<off; H -> 4'b0011<<off; W -> 4'b1111.
- Store wdata: B -> byte replicated ×4; H -> half replicated ×2; W -> rs2_data.
- REQ: dmem_req and all dmem_* stable until dmem_ack.
  - On ack: dmem_req=0 next cycle; load lane extracted at off.
    - LB/LH sign-extend; LBU/LHU zero-extend; LW full word.
  - Go DONE.
- DONE, one cycle: wb_valid=1, wb_data = extended load (0 for stores), wb_err=0; next state IDLE, in_ready=1.
- Latency: non-mem 1 cycle. Mem op: 1 + N + 1 cycles, where N ≥ 1 is cycles from dmem_req rise to dmem_ack inclusive.
- dmem_ack outside REQ: ignored.
- rst mid-REQ: dmem_req drops next cycle; the in-flight op is discarded with no wb_valid.
- Downstream never stalls; wb_valid is a one-cycle pulse per instruction.

Decomposition:
- Shared definitions: OP_LOAD, OP_STORE opcodes; funct3 codes F3_B, F3_H, F3_W, F3_BU, F3_HU; FSM state encodings.
- Single sub-module lsu_align: combinational be/wdata generation and load extract/extend from funct3 and off. Reused by any later cache or MMIO path.

Test Plan:
- Reset, then OP with alu_res=32'h1234, rd=5 -> next cycle wb_valid=1, wb_data=32'h1234, wb_rd=5, wb_err=0.
- SB rs2_data=32'hAB, alu_res=32'h103 -> dmem_be=4'b1000, dmem_addr=32'h100, dmem_wdata=32'hABABABAB, dmem_we=1. Ack after 3 cycles -> DONE pulse with wb_data=0; in_ready low throughout.
- LB from 32'h101, rdata=32'h0000_8000 -> wb_data=32'hFFFF_FF80. LBU, same address and data -> 32'h0000_0080.
- LH at 32'h102, rdata=32'h8001_0000 -> wb_data=32'hFFFF_8001. LW at 32'h102 -> no dmem_req; wb_err=1, wb_data=0.
- Back-to-back: OP, LW (ack immediate), OP -> wb_valid pulses in order. The second OP is held off by in_ready=0 and accepted only in the cycle after DONE.
- rst asserted during REQ -> dmem_req=0 next cycle, no wb_valid. A later stray dmem_ack is ignored, and the next instruction completes normally.
